// File: rtl/mac_acc_pkg.sv
// Shared types and sizing helpers for the multiply-add result accumulator.
package mac_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int K_W = 16;

  // Counter must be able to hold N itself, so size for N+1 values.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mac_result_accumulator_acc_lane.sv
// One accumulator lane: extends a 16-bit sample, adds modulo 2^ACC_W and tracks a sticky overflow.
// sum_nxt_o/ovf_nxt_o show the totals including the current sample so the top can capture the final one.
module acc_lane
  import mac_acc_pkg::*;
#(
  parameter int ACC_W  = 24,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             add_i,
  input  logic [K_W-1:0]   k_i,
  output logic [ACC_W-1:0] sum_nxt_o,
  output logic             ovf_nxt_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic signed [K_W-1:0] k_s;
  logic [ACC_W-1:0]      ext_s, ext_u, ext;
  logic [ACC_W:0]        sum_w;
  logic                  carry, sovf, ovf_now;

  assign k_s   = k_i;
  assign ext_s = ACC_W'(k_s);
  assign ext_u = ACC_W'(k_i);
  assign ext   = SIGNED ? ext_s : ext_u;

  assign sum_w = {1'b0, acc_q} + {1'b0, ext};
  assign carry = sum_w[ACC_W];
  // Signed overflow: same-sign operands producing a result of the other sign.
  assign sovf  = (acc_q[ACC_W-1] == ext[ACC_W-1]) && (sum_w[ACC_W-1] != acc_q[ACC_W-1]);

  assign ovf_now   = add_i && (SIGNED ? sovf : carry);
  assign sum_nxt_o = add_i ? sum_w[ACC_W-1:0] : acc_q;
  assign ovf_nxt_o = ovf_q || ovf_now;

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (add_i) begin
      acc_d = sum_w[ACC_W-1:0];
      ovf_d = ovf_nxt_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/mac_result_accumulator.sv
// Sums N accepted multiply-add results into unsigned/signed totals with sticky overflow flags.
// Result appears the cycle after the N-th accept and is held (in_ready=0) until out_ready.
module mac_result_accumulator
  import mac_acc_pkg::*;
#(
  parameter int N     = 4,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K_W-1:0]   k_usgn,
  input  logic [K_W-1:0]   k_sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum_usgn,
  output logic [ACC_W-1:0] sum_sgn,
  output logic             ovf_usgn,
  output logic             ovf_sgn
);

  localparam int CW = cnt_w(N);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0] sum_u_q, sum_u_d, sum_s_q, sum_s_d;
  logic             ovf_u_q, ovf_u_d, ovf_s_q, ovf_s_d;

  logic             accept, last, lane_clr;
  logic [ACC_W-1:0] u_nxt, s_nxt;
  logic             u_ovf_nxt, s_ovf_nxt;

  // clear outranks the handshake, so a sample offered alongside it is dropped.
  assign accept   = in_valid && (state_q == ACCUM) && !clear;
  assign last     = accept && (cnt_q == CW'(N - 1));
  assign lane_clr = clear || last;

  acc_lane #(.ACC_W(ACC_W), .SIGNED(1'b0)) u_lane_u (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (lane_clr),
    .add_i     (accept),
    .k_i       (k_usgn),
    .sum_nxt_o (u_nxt),
    .ovf_nxt_o (u_ovf_nxt)
  );

  acc_lane #(.ACC_W(ACC_W), .SIGNED(1'b1)) u_lane_s (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (lane_clr),
    .add_i     (accept),
    .k_i       (k_sgn),
    .sum_nxt_o (s_nxt),
    .ovf_nxt_o (s_ovf_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_u_d = sum_u_q;
    sum_s_d = sum_s_q;
    ovf_u_d = ovf_u_q;
    ovf_s_d = ovf_s_q;
    if (clear) begin
      state_d = ACCUM;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (last) begin
            state_d = HOLD;
            cnt_d   = '0;
            sum_u_d = u_nxt;
            sum_s_d = s_nxt;
            ovf_u_d = u_ovf_nxt;
            ovf_s_d = s_ovf_nxt;
          end else if (accept) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        HOLD: begin
          if (out_ready) state_d = ACCUM;
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      sum_u_q <= '0;
      sum_s_q <= '0;
      ovf_u_q <= 1'b0;
      ovf_s_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_u_q <= sum_u_d;
      sum_s_q <= sum_s_d;
      ovf_u_q <= ovf_u_d;
      ovf_s_q <= ovf_s_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign sum_usgn  = sum_u_q;
  assign sum_sgn   = sum_s_q;
  assign ovf_usgn  = ovf_u_q;
  assign ovf_sgn   = ovf_s_q;

endmodule

// File: tb/tb_mac_result_accumulator.sv
// Drives an N=4/ACC_W=24 and an N=2/ACC_W=16 accumulator with identical inputs
// and compares both against an integer-arithmetic frame model.
module tb_mac_result_accumulator;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, out_ready;
  logic [15:0] k_usgn, k_sgn;

  logic        rdy4, vld4, fu4, fs4;
  logic [23:0] su4, ss4;
  logic        rdy2, vld2, fu2, fs2;
  logic [15:0] su2, ss2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mac_result_accumulator #(.N(4), .ACC_W(24)) u_dut4 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy4),
    .k_usgn(k_usgn), .k_sgn(k_sgn), .out_valid(vld4), .out_ready(out_ready),
    .sum_usgn(su4), .sum_sgn(ss4), .ovf_usgn(fu4), .ovf_sgn(fs4)
  );

  mac_result_accumulator #(.N(2), .ACC_W(16)) u_dut2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy2),
    .k_usgn(k_usgn), .k_sgn(k_sgn), .out_valid(vld2), .out_ready(out_ready),
    .sum_usgn(su2), .sum_sgn(ss2), .ovf_usgn(fu2), .ovf_sgn(fs2)
  );

  // Reference model: index 0 is the N=4 instance, index 1 the N=2 instance.
  int     nn[2] = '{4, 2};
  int     ww[2] = '{24, 16};
  bit     m_hold[2];
  int     m_cnt[2];
  longint m_au[2], m_as[2];
  bit     m_fu[2], m_fs[2];
  longint m_ou[2], m_os[2];
  bit     m_ofu[2], m_ofs[2];

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input bit r, input bit c, input bit v,
                            input logic [15:0] ku, input logic [15:0] ks, input bit ordy);
    longint span, smax, smin, t;
    span = longint'(1) << ww[i];
    smax = (span >> 1) - 1;
    smin = -(span >> 1);
    if (r) begin
      m_hold[i] = 0; m_cnt[i] = 0; m_au[i] = 0; m_as[i] = 0; m_fu[i] = 0; m_fs[i] = 0;
      m_ou[i] = 0; m_os[i] = 0; m_ofu[i] = 0; m_ofs[i] = 0;
    end else if (c) begin
      m_hold[i] = 0; m_cnt[i] = 0; m_au[i] = 0; m_as[i] = 0; m_fu[i] = 0; m_fs[i] = 0;
    end else if (!m_hold[i]) begin
      if (v) begin
        t = m_au[i] + longint'(ku);
        if (t >= span) begin m_fu[i] = 1; t -= span; end
        m_au[i] = t;
        t = m_as[i] + longint'($signed(ks));
        if (t > smax) begin m_fs[i] = 1; t -= span; end
        else if (t < smin) begin m_fs[i] = 1; t += span; end
        m_as[i] = t;
        m_cnt[i]++;
        if (m_cnt[i] == nn[i]) begin
          m_ou[i] = m_au[i]; m_os[i] = m_as[i]; m_ofu[i] = m_fu[i]; m_ofs[i] = m_fs[i];
          m_hold[i] = 1; m_cnt[i] = 0; m_au[i] = 0; m_as[i] = 0; m_fu[i] = 0; m_fs[i] = 0;
        end
      end
    end else if (ordy) begin
      m_hold[i] = 0;
    end
  endtask

  task automatic compare_all();
    chk("rdy4", longint'(rdy4), longint'(!m_hold[0]));
    chk("vld4", longint'(vld4), longint'(m_hold[0]));
    chk("rdy2", longint'(rdy2), longint'(!m_hold[1]));
    chk("vld2", longint'(vld2), longint'(m_hold[1]));
    if (m_hold[0]) begin
      chk("su4", longint'(su4), m_ou[0]);
      chk("ss4", longint'($signed(ss4)), m_os[0]);
      chk("fu4", longint'(fu4), longint'(m_ofu[0]));
      chk("fs4", longint'(fs4), longint'(m_ofs[0]));
    end
    if (m_hold[1]) begin
      chk("su2", longint'(su2), m_ou[1]);
      chk("ss2", longint'($signed(ss2)), m_os[1]);
      chk("fu2", longint'(fu2), longint'(m_ofu[1]));
      chk("fs2", longint'(fs2), longint'(m_ofs[1]));
    end
  endtask

  task automatic step(input bit r, input bit c, input bit v,
                      input logic [15:0] ku, input logic [15:0] ks, input bit ordy);
    rst = r; clear = c; in_valid = v; k_usgn = ku; k_sgn = ks; out_ready = ordy;
    @(posedge clk);
    model_step(0, r, c, v, ku, ks, ordy);
    model_step(1, r, c, v, ku, ks, ordy);
    #1;
    compare_all();
  endtask

  int bub_v[7] = '{1, 0, 1, 0, 0, 1, 1};

  initial begin
    int n;
    rst = 1; clear = 0; in_valid = 0; out_ready = 0; k_usgn = 0; k_sgn = 0;
    #1;
    step(1, 0, 0, 16'h0, 16'h0, 0);
    step(1, 0, 0, 16'h0, 16'h0, 0);
    chk("rst_su4", longint'(su4), 0);
    chk("rst_ss4", longint'(ss4), 0);
    chk("rst_flags", longint'({fu4, fs4, fu2, fs2}), 0);

    // Four distinct values, out_ready held high.
    step(0, 0, 1, 16'h0010, 16'hFFFF, 1);
    step(0, 0, 1, 16'h0020, 16'hFFFF, 1);
    step(0, 0, 1, 16'h0030, 16'hFFFF, 1);
    step(0, 0, 1, 16'h0040, 16'hFFFF, 1);
    chk("t1_vld", longint'(vld4), 1);
    chk("t1_rdy", longint'(rdy4), 0);
    chk("t1_su", longint'(su4), 'hA0);
    chk("t1_ss", longint'(ss4), 'hFFFFFC);
    chk("t1_flags", longint'({fu4, fs4}), 0);
    step(0, 0, 0, 16'h0, 16'h0, 1);
    chk("t1_rdy_back", longint'(rdy4), 1);

    // Overflow on the 16-bit instance, then a clean frame.
    step(0, 1, 0, 16'h0, 16'h0, 1);
    step(0, 0, 1, 16'hFFFF, 16'h7FFF, 1);
    step(0, 0, 1, 16'hFFFF, 16'h0001, 1);
    chk("t2_su", longint'(su2), 'hFFFE);
    chk("t2_fu", longint'(fu2), 1);
    chk("t2_ss", longint'(ss2), 'h8000);
    chk("t2_fs", longint'(fs2), 1);
    step(0, 0, 0, 16'h0, 16'h0, 1);
    step(0, 0, 1, 16'h0001, 16'h0001, 1);
    step(0, 0, 1, 16'h0001, 16'h0001, 1);
    chk("t2b_su", longint'(su2), 2);
    chk("t2b_flags", longint'({fu2, fs2}), 0);

    // Backpressure: result must hold while out_ready is low.
    step(0, 1, 0, 16'h0, 16'h0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'(5 + i), 16'h0, 0);
    chk("t3_vld", longint'(vld4), 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 16'($urandom), 16'($urandom), 0);
      chk("t3_hold_su", longint'(su4), 26);
      chk("t3_hold_rdy", longint'(rdy4), 0);
    end
    step(0, 0, 0, 16'h0, 16'h0, 1);
    chk("t3_rdy_after", longint'(rdy4), 1);

    // Bubbles stall the count.
    step(0, 1, 0, 16'h0, 16'h0, 1);
    n = 1;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) chk("t4_vld_early", longint'(vld4), 0);
      step(0, 0, bub_v[i] != 0, 16'(n), 16'(n), 1);
      if (bub_v[i] != 0) n++;
    end
    chk("t4_vld", longint'(vld4), 1);
    chk("t4_su", longint'(su4), 10);

    // Abort mid-frame.
    step(0, 1, 0, 16'h0, 16'h0, 1);
    step(0, 0, 1, 16'h0007, 16'h0007, 1);
    step(0, 0, 1, 16'h0007, 16'h0007, 1);
    step(0, 1, 1, 16'h0007, 16'h0007, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h0001, 16'h0001, 1);
    chk("t5_su", longint'(su4), 4);

    // Reset while holding a result.
    step(0, 1, 0, 16'h0, 16'h0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h0101, 16'h8000, 0);
    chk("t6_vld_pre", longint'(vld4), 1);
    step(1, 0, 0, 16'h0, 16'h0, 0);
    chk("t6_vld", longint'(vld4), 0);
    chk("t6_rdy", longint'(rdy4), 1);
    chk("t6_sums", longint'({su4, ss4}), 0);

    // Randomized traffic, biased toward large magnitudes to hit overflow.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ku, ks;
      ku = ($urandom_range(0, 3) == 0) ? 16'($urandom) : (16'hFFFF - 16'($urandom_range(0, 255)));
      ks = ($urandom_range(0, 1) == 0) ? 16'($urandom) :
           (($urandom_range(0, 1) == 0) ? 16'h7F00 : 16'h8100);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 9) < 7, ku, ks, $urandom_range(0, 9) < 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
